// File: rtl/synfifo_pkg.sv
// Shared types, default sizes and the configuration check for synfifo_prog.
package synfifo_pkg;

   typedef enum logic {RD_STD, RD_FWFT} rd_mode_e;

   localparam int SYNFIFO_DEF_WIDTH = 8;
   localparam int SYNFIFO_DEF_DEPTH = 16;

   // True when depth is a power of two >= 2 and both thresholds lie in range.
   function automatic bit synfifo_cfg_ok(input int depth, input int af_level, input int ae_level);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (af_level >= 1) && (af_level <= depth) &&
             (ae_level >= 0) && (ae_level < depth);
   endfunction

endpackage

// File: rtl/synfifo_mem.sv
// Storage array for synfifo_prog: one synchronous write port, one asynchronous read port.
module synfifo_mem
   import synfifo_pkg::*;
#(
   parameter int width = SYNFIFO_DEF_WIDTH,
   parameter int depth = SYNFIFO_DEF_DEPTH,
   parameter int addr  = $clog2(depth)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [addr-1:0]   waddr,
   input  logic [width-1:0]  wdata,
   input  logic [addr-1:0]   raddr,
   output logic [width-1:0]  rdata
);

   logic [width-1:0] mem [depth];

   // NOTE: the array has no reset; contents are only meaningful once written.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/synfifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags and std/FWFT read.
// Define SYNFIFO_ERR_EN to build the sticky overflow/underflow flags.
module synfifo_prog
   import synfifo_pkg::*;
#(
   parameter int width    = SYNFIFO_DEF_WIDTH,
   parameter int depth    = SYNFIFO_DEF_DEPTH,
   parameter int af_level = depth - 2,
   parameter int ae_level = 2,
   parameter int fwft     = 0,
   parameter int addr     = $clog2(depth)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [width-1:0]  wdata,
   input  logic              ren,
   output logic [width-1:0]  rdata,
   output logic              rvalid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [addr:0]     count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   typedef logic [addr:0] ptr_t;

   localparam rd_mode_e rd_mode = (fwft != 0) ? RD_FWFT : RD_STD;

   if (!synfifo_cfg_ok(depth, af_level, ae_level) || width < 1) begin : g_bad_cfg
      $error("synfifo_prog: depth must be a power of two >= 2 and thresholds in range");
   end

   ptr_t             wptr, rptr;
   logic             wr_acc, rd_acc;
   logic [width-1:0] mem_rdata;

   // Extra pointer bit distinguishes full from empty; the subtraction wraps naturally.
   assign count        = wptr - rptr;
   assign full         = (count == ptr_t'(depth));
   assign empty        = (count == '0);
   assign almost_full  = (count >= ptr_t'(af_level));
   assign almost_empty = (count <= ptr_t'(ae_level));

   assign wr_acc = wen && !full;
   assign rd_acc = ren && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
      end
   end

   synfifo_mem #(.width(width), .depth(depth), .addr(addr)) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr[addr-1:0]),
      .wdata (wdata),
      .raddr (rptr[addr-1:0]),
      .rdata (mem_rdata)
   );

   if (rd_mode == RD_FWFT) begin : g_fwft
      // Head word is shown whenever present; zero keeps rdata clean while empty.
      assign rdata  = empty ? '0 : mem_rdata;
      assign rvalid = !empty;
   end else begin : g_std
      logic [width-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem_rdata;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

`ifdef SYNFIFO_ERR_EN
   logic ovf_q, udf_q;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q && !err_clr) || (wen && full);
         udf_q <= (udf_q && !err_clr) || (ren && empty);
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_synfifo_prog.sv
// Directed bench for synfifo_prog: standard depth-16, wrap on depth-4, and FWFT instances.
module tb_synfifo_prog;
   import synfifo_pkg::*;

`ifdef SYNFIFO_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Standard-mode instance, depth 16
   logic       s_wen, s_ren, s_err_clr, s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic [7:0] s_wdata, s_rdata;
   logic [4:0] s_count;

   // Small instance for pointer wrap, depth 4
   logic       p_wen, p_ren, p_err_clr, p_rvalid, p_full, p_empty, p_af, p_ae, p_ovf, p_udf;
   logic [7:0] p_wdata, p_rdata;
   logic [2:0] p_count;

   // FWFT instance, depth 16
   logic       f_wen, f_ren, f_err_clr, f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [7:0] f_wdata, f_rdata;
   logic [4:0] f_count;

   synfifo_prog #(.width(8), .depth(16), .af_level(14), .ae_level(2), .fwft(0)) u_std (
      .clk(clk), .rst(rst), .wen(s_wen), .wdata(s_wdata), .ren(s_ren), .rdata(s_rdata),
      .rvalid(s_rvalid), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .err_clr(s_err_clr), .overflow(s_ovf),
      .underflow(s_udf));

   synfifo_prog #(.width(8), .depth(4), .af_level(3), .ae_level(1), .fwft(0)) u_small (
      .clk(clk), .rst(rst), .wen(p_wen), .wdata(p_wdata), .ren(p_ren), .rdata(p_rdata),
      .rvalid(p_rvalid), .full(p_full), .empty(p_empty), .almost_full(p_af),
      .almost_empty(p_ae), .count(p_count), .err_clr(p_err_clr), .overflow(p_ovf),
      .underflow(p_udf));

   synfifo_prog #(.width(8), .depth(16), .af_level(14), .ae_level(2), .fwft(1)) u_fwft (
      .clk(clk), .rst(rst), .wen(f_wen), .wdata(f_wdata), .ren(f_ren), .rdata(f_rdata),
      .rvalid(f_rvalid), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .err_clr(f_err_clr), .overflow(f_ovf),
      .underflow(f_udf));

   // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (s_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", s_count); end
      checks++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got empty/ae/full/af=%b expected 1100", {s_empty, s_ae, s_full, s_af}); end
      checks++; if ({s_rdata, s_rvalid} !== 9'd0) begin errors++; $display("FAIL reset_rdata: got rdata=%h rvalid=%b expected 00/0", s_rdata, s_rvalid); end
      checks++; if ({s_ovf, s_udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got ovf/udf=%b expected 00", {s_ovf, s_udf}); end
      checks++; if ({f_empty, f_rvalid, f_rdata} !== {1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL reset_fwft: got empty=%b rvalid=%b rdata=%h expected 1/0/00", f_empty, f_rvalid, f_rdata); end
   endtask

   // Writes 0x00..0x0F, then one write into a full FIFO.
   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         s_wen = 1'b1; s_wdata = 8'(i);
         step();
         checks++; if (s_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_count, i + 1); end
         checks++; if ({s_ae, s_af, s_full} !== {(i + 1) <= 2, (i + 1) >= 14, (i + 1) == 16}) begin
            errors++; $display("FAIL fill_flags[%0d]: got ae/af/full=%b%b%b", i, s_ae, s_af, s_full);
         end
      end
      s_wdata = 8'hFF;
      step();
      s_wen = 1'b0;
      checks++; if ({s_count, s_full} !== {5'd16, 1'b1}) begin errors++; $display("FAIL overfill_count: got count=%0d full=%b expected 16/1", s_count, s_full); end
      checks++; if (s_ovf !== EXP_ERR) begin errors++; $display("FAIL overflow_flag: got %b expected %b", s_ovf, EXP_ERR); end
   endtask

   task automatic test_drain_std();
      s_ren = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         checks++; if ({s_rvalid, s_rdata, s_count} !== {1'b1, 8'(k - 1), 5'(16 - k)}) begin
            errors++; $display("FAIL drain[%0d]: got rvalid=%b rdata=%h count=%0d expected 1/%h/%0d", k, s_rvalid, s_rdata, s_count, 8'(k - 1), 16 - k);
         end
      end
      step();
      s_ren = 1'b0;
      checks++; if ({s_rvalid, s_rdata, s_count} !== {1'b0, 8'h0F, 5'd0}) begin errors++; $display("FAIL underread: got rvalid=%b rdata=%h count=%0d expected 0/0f/0", s_rvalid, s_rdata, s_count); end
      checks++; if (s_udf !== EXP_ERR) begin errors++; $display("FAIL underflow_flag: got %b expected %b", s_udf, EXP_ERR); end
`ifdef SYNFIFO_ERR_EN
      s_ren = 1'b1; s_err_clr = 1'b1;
      step();
      s_ren = 1'b0;
      checks++; if ({s_ovf, s_udf} !== 2'b01) begin errors++; $display("FAIL err_set_wins: got ovf/udf=%b expected 01", {s_ovf, s_udf}); end
      step();
      s_err_clr = 1'b0;
      checks++; if ({s_ovf, s_udf} !== 2'b00) begin errors++; $display("FAIL err_clear: got ovf/udf=%b expected 00", {s_ovf, s_udf}); end
`endif
   endtask

   task automatic test_wrap();
      int max_count = 0;
      for (int i = 0; i < 20; i++) begin
         p_wen = 1'b1; p_wdata = 8'(i * 7 + 3);
         step();
         p_wen = 1'b0;
         if (int'(p_count) > max_count) max_count = int'(p_count);
         p_ren = 1'b1;
         step();
         p_ren = 1'b0;
         if (int'(p_count) > max_count) max_count = int'(p_count);
         checks++; if ({p_rvalid, p_rdata} !== {1'b1, 8'(i * 7 + 3)}) begin
            errors++; $display("FAIL wrap_data[%0d]: got rvalid=%b rdata=%h expected 1/%h", i, p_rvalid, p_rdata, 8'(i * 7 + 3));
         end
      end
      checks++; if (max_count !== 1) begin errors++; $display("FAIL wrap_max_count: got %0d expected 1", max_count); end
   endtask

   task automatic test_simultaneous();
      s_wen = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_wdata = 8'(8'h80 + i);
         step();
      end
      checks++; if (s_count !== 5'd16) begin errors++; $display("FAIL simul_fill: got %0d expected 16", s_count); end
      s_ren = 1'b1; s_wdata = 8'hEE;
      step();
      s_wen = 1'b0;
      checks++; if ({s_count, s_rvalid, s_rdata} !== {5'd15, 1'b1, 8'h80}) begin
         errors++; $display("FAIL simul_full: got count=%0d rvalid=%b rdata=%h expected 15/1/80", s_count, s_rvalid, s_rdata);
      end
      for (int k = 1; k <= 15; k++) begin
         step();
         checks++; if (s_rdata !== 8'(8'h80 + k)) begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", k, s_rdata, 8'(8'h80 + k)); end
      end
      s_ren = 1'b0;
      step();
      s_wen = 1'b1; s_ren = 1'b1; s_wdata = 8'h55;
      step();
      s_wen = 1'b0;
      checks++; if ({s_count, s_rvalid} !== {5'd1, 1'b0}) begin errors++; $display("FAIL simul_empty: got count=%0d rvalid=%b expected 1/0", s_count, s_rvalid); end
      step();
      s_ren = 1'b0;
      checks++; if ({s_count, s_rvalid, s_rdata} !== {5'd0, 1'b1, 8'h55}) begin
         errors++; $display("FAIL simul_empty_read: got count=%0d rvalid=%b rdata=%h expected 0/1/55", s_count, s_rvalid, s_rdata);
      end
   endtask

   task automatic test_fwft();
      f_wen = 1'b1; f_wdata = 8'hA5;
      step();
      f_wen = 1'b0;
      checks++; if ({f_rvalid, f_rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL fwft_show: got rvalid=%b rdata=%h expected 1/a5", f_rvalid, f_rdata); end
      f_ren = 1'b1;
      step();
      f_ren = 1'b0;
      checks++; if ({f_empty, f_rvalid} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got empty=%b rvalid=%b expected 1/0", f_empty, f_rvalid); end
      f_wen = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         f_wdata = 8'(8'h11 * i);
         step();
      end
      f_wen = 1'b0;
      f_ren = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         checks++; if ({f_rvalid, f_rdata} !== {1'b1, 8'(8'h11 * i)}) begin
            errors++; $display("FAIL fwft_b2b[%0d]: got rvalid=%b rdata=%h expected 1/%h", i, f_rvalid, f_rdata, 8'(8'h11 * i));
         end
         step();
      end
      f_ren = 1'b0;
      checks++; if ({f_empty, f_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL fwft_drained: got empty=%b count=%0d expected 1/0", f_empty, f_count); end
   endtask

   task automatic test_mid_reset();
      s_wen = 1'b1;
      for (int i = 0; i < 17; i++) begin
         s_wdata = 8'(i);
         step();
      end
      s_wen = 1'b0;
      s_ren = 1'b1;
      for (int i = 0; i < 9; i++) step();
      s_ren = 1'b0;
      checks++; if ({s_count, s_ovf} !== {5'd7, EXP_ERR}) begin errors++; $display("FAIL pre_reset: got count=%0d ovf=%b expected 7/%b", s_count, s_ovf, EXP_ERR); end
      #3;
      rst = 1'b0;
      #1;
      checks++; if ({s_count, s_empty, s_rdata, s_ovf, s_rvalid} !== {5'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset: got count=%0d empty=%b rdata=%h ovf=%b rvalid=%b expected 0/1/00/0/0", s_count, s_empty, s_rdata, s_ovf, s_rvalid);
      end
      step();
      rst = 1'b1;
      step();
      s_wen = 1'b1; s_wdata = 8'h3C;
      step();
      s_wen = 1'b0; s_ren = 1'b1;
      step();
      s_ren = 1'b0;
      checks++; if ({s_rvalid, s_rdata, s_count} !== {1'b1, 8'h3C, 5'd0}) begin
         errors++; $display("FAIL post_reset_read: got rvalid=%b rdata=%h count=%0d expected 1/3c/0", s_rvalid, s_rdata, s_count);
      end
   endtask

   initial begin
      rst = 1'b0;
      {s_wen, s_ren, s_err_clr, s_wdata} = '0;
      {p_wen, p_ren, p_err_clr, p_wdata} = '0;
      {f_wen, f_ren, f_err_clr, f_wdata} = '0;
      step();
      step();
      rst = 1'b1;
      step();
      test_reset();
      test_fill();
      test_drain_std();
      test_wrap();
      test_simultaneous();
      test_fwft();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
